// File: rtl/softreg_arbiter_pkg.sv
// Shared types and defaults for the SoftReg round-robin arbiter.
// Optional statistics build macro: SOFTREG_ARB_STATS_EN.
package softreg_arbiter_pkg;

    localparam int SR_ARB_NUM_REQ_DEFAULT         = 2;
    localparam int SR_ARB_LOG_OUTSTANDING_DEFAULT = 3;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} SrArbState;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    function automatic int sr_arb_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/softreg_arbiter_if.sv
// Upstream/downstream SoftReg signal bundle around the arbiter.
// slave = arbiter view, master = environment (bridges + decoder) view.
interface softreg_arbiter_if
    import softreg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = SR_ARB_NUM_REQ_DEFAULT
) ();

    SoftRegReq              up_req [NUM_REQ];
    logic [NUM_REQ-1:0]     up_req_grant;
    SoftRegResp             up_resp [NUM_REQ];
    logic [NUM_REQ-1:0]     up_resp_grant;
    SoftRegReq              dn_req;
    logic                   dn_req_grant;
    SoftRegResp             dn_resp;
    logic                   dn_resp_grant;
    logic                   busy;

    modport slave (
        input  up_req, up_resp_grant, dn_req_grant, dn_resp,
        output up_req_grant, up_resp, dn_req, dn_resp_grant, busy
    );

    modport master (
        output up_req, up_resp_grant, dn_req_grant, dn_resp,
        input  up_req_grant, up_resp, dn_req, dn_resp_grant, busy
    );

endinterface

// File: rtl/softreg_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for granted reads; async active-low reset,
// full/empty flags and an occupancy count.
module sr_arb_id_fifo #(
    parameter int ID_W      = 1,
    parameter int LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [ID_W-1:0]      i_push_id,
    input  logic                 i_pop,
    output logic [ID_W-1:0]      o_head_id,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [LOG_DEPTH:0]   o_count
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [ID_W-1:0]      r_mem [DEPTH];
    logic [LOG_DEPTH-1:0] r_wr_ptr;
    logic [LOG_DEPTH-1:0] r_rd_ptr;
    logic [LOG_DEPTH:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_id;
    end

    // Pointers wrap naturally at 2^LOG_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_id = r_mem[r_rd_ptr];
    // Count never exceeds DEPTH, so its MSB alone marks full.
    assign o_full    = r_count[LOG_DEPTH];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

endmodule

// File: rtl/softreg_arbiter.sv
// Round-robin arbiter sharing one SoftReg channel among NUM_REQ masters,
// routing read responses via an ID FIFO. Stats ports: SOFTREG_ARB_STATS_EN.
//
//   state  | meaning
//   IDLE   | round-robin search over eligible requesters, zero-cycle grant
//   LOCKED | decoder stalled; dn_req held on lock_id until granted
module softreg_arbiter
    import softreg_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = SR_ARB_NUM_REQ_DEFAULT,
    parameter int LOG_OUTSTANDING = SR_ARB_LOG_OUTSTANDING_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    softreg_arbiter_if.slave          bus
`ifdef SOFTREG_ARB_STATS_EN
    ,
    output logic [31:0]               stat_grants [NUM_REQ],
    output logic [LOG_OUTSTANDING:0]  stat_max_outstanding,
    output logic                      err_unsolicited
`endif
);

    localparam int ID_W = sr_arb_id_w(NUM_REQ);
    localparam logic [0:0] S_IDLE   = ARB_IDLE;
    localparam logic [0:0] S_LOCKED = ARB_LOCKED;

    logic [0:0]              r_state;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [ID_W-1:0]         r_lock_id;

    logic [NUM_REQ-1:0]      w_eligible;
    logic                    w_found;
    logic [ID_W-1:0]         w_sel;
    logic [ID_W-1:0]         w_cur_id;
    logic [ID_W-1:0]         w_next_ptr;
    logic                    w_req_valid;
    logic                    w_fire;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [ID_W-1:0]         w_head;
    logic [LOG_OUTSTANDING:0] w_count;

    // Eligibility uses the registered full flag; a same-cycle pop does not help.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            w_eligible[i] = bus.up_req[i].valid && (bus.up_req[i].isWrite || !w_full);
    end

    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && w_eligible[idx]) begin
                w_found = 1'b1;
                w_sel   = ID_W'(idx);
            end
        end
    end

    assign w_cur_id    = (r_state == S_LOCKED) ? r_lock_id : w_sel;
    assign w_req_valid = rst_n && ((r_state == S_LOCKED) ? bus.up_req[r_lock_id].valid : w_found);
    assign w_fire      = w_req_valid && bus.dn_req_grant;
    assign w_push      = w_fire && !bus.up_req[w_cur_id].isWrite;
    assign w_next_ptr  = (w_cur_id == ID_W'(NUM_REQ - 1)) ? '0 : w_cur_id + 1'b1;

    always_comb begin
        bus.dn_req       = bus.up_req[w_cur_id];
        bus.dn_req.valid = w_req_valid;
        bus.up_req_grant = '0;
        if (w_fire) bus.up_req_grant[w_cur_id] = 1'b1;
    end

    // A dropped valid while LOCKED is a protocol error: release without grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_lock_id <= '0;
        end else begin
            if (w_fire) r_rr_ptr <= w_next_ptr;
            case (r_state)
                S_IDLE: begin
                    if (w_found && !bus.dn_req_grant) begin
                        r_state   <= S_LOCKED;
                        r_lock_id <= w_sel;
                    end
                end
                default: begin
                    if (w_fire || !bus.up_req[r_lock_id].valid) r_state <= S_IDLE;
                end
            endcase
        end
    end

    sr_arb_id_fifo #(
        .ID_W      (ID_W),
        .LOG_DEPTH (LOG_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_push_id (w_cur_id),
        .i_pop     (w_pop),
        .o_head_id (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign w_pop = rst_n && bus.dn_resp.valid && !w_empty && bus.up_resp_grant[w_head];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.up_resp[i].data  = bus.dn_resp.data;
            bus.up_resp[i].valid = rst_n && bus.dn_resp.valid && !w_empty && (w_head == ID_W'(i));
        end
    end

    // Responses with no outstanding read are swallowed so the decoder never stalls.
    assign bus.dn_resp_grant = w_pop || (rst_n && bus.dn_resp.valid && w_empty);
    assign bus.busy          = (r_state == S_LOCKED) || (w_count != '0);

`ifdef SOFTREG_ARB_STATS_EN
    logic [31:0]              r_stat_grants [NUM_REQ];
    logic [LOG_OUTSTANDING:0] r_stat_max;
    logic                     r_err_unsolicited;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) r_stat_grants[i] <= '0;
            r_stat_max        <= '0;
            r_err_unsolicited <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.up_req_grant[i] && (r_stat_grants[i] != '1))
                    r_stat_grants[i] <= r_stat_grants[i] + 1'b1;
            end
            if (w_count > r_stat_max) r_stat_max <= w_count;
            if (bus.dn_resp.valid && w_empty) r_err_unsolicited <= 1'b1;
        end
    end

    assign stat_grants          = r_stat_grants;
    assign stat_max_outstanding = r_stat_max;
    assign err_unsolicited      = r_err_unsolicited;
`endif

endmodule

// File: tb/tb_softreg_arbiter.sv
// Self-checking bench for softreg_arbiter (NUM_REQ=2, LOG_OUTSTANDING=1);
// stats ports are checked when SOFTREG_ARB_STATS_EN is defined.
module tb_softreg_arbiter;
    import softreg_arbiter_pkg::*;

    localparam int NR  = 2;
    localparam int LOG = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    softreg_arbiter_if #(.NUM_REQ(NR)) bus ();

`ifdef SOFTREG_ARB_STATS_EN
    logic [31:0]  stat_grants [NR];
    logic [LOG:0] stat_max;
    logic         err_unsol;
`endif

    softreg_arbiter #(
        .NUM_REQ         (NR),
        .LOG_OUTSTANDING (LOG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef SOFTREG_ARB_STATS_EN
        ,
        .stat_grants          (stat_grants),
        .stat_max_outstanding (stat_max),
        .err_unsolicited      (err_unsol)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_grants [NR];

    typedef struct {
        logic [NR-1:0] v, wr;
        logic [31:0]   a0, a1;
        logic          dgnt, rv;
        logic [NR-1:0] rg;
        logic [63:0]   rd;
        logic          edv;
        int            esel;
        logic [NR-1:0] eug, erv;
        logic          edrg, ebusy;
    } vec_t;

    typedef struct {
        int          id;
        logic [63:0] data;
    } sb_t;

    sb_t  sb_q [$];
    vec_t tv [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] req_data(input int i, input logic [31:0] addr);
        return {32'hDA7A_0000 + 32'(i), addr};
    endfunction

    function automatic vec_t mkv(input logic [NR-1:0] v, input logic [NR-1:0] wr,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic dgnt, input logic rv, input logic [NR-1:0] rg,
                                 input logic [63:0] rd, input logic edv, input int esel,
                                 input logic [NR-1:0] eug, input logic [NR-1:0] erv,
                                 input logic edrg, input logic ebusy);
        vec_t t;
        t.v = v; t.wr = wr; t.a0 = a0; t.a1 = a1; t.dgnt = dgnt; t.rv = rv; t.rg = rg;
        t.rd = rd; t.edv = edv; t.esel = esel; t.eug = eug; t.erv = erv;
        t.edrg = edrg; t.ebusy = ebusy;
        return t;
    endfunction

    task automatic drive_req(input int i, input logic v, input logic wr, input logic [31:0] addr);
        bus.up_req[i].valid   = v;
        bus.up_req[i].isWrite = wr;
        bus.up_req[i].addr    = addr;
        bus.up_req[i].data    = req_data(i, addr);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NR; i++) drive_req(i, 1'b0, 1'b0, 32'h0);
        bus.dn_req_grant   = 1'b0;
        bus.dn_resp.valid  = 1'b0;
        bus.dn_resp.data   = '0;
        bus.up_resp_grant  = '0;
    endtask

    function automatic logic [NR-1:0] resp_valids();
        logic [NR-1:0] r;
        for (int i = 0; i < NR; i++) r[i] = bus.up_resp[i].valid;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t t, input int row);
        logic [31:0] ea;
        drive_req(0, t.v[0], t.wr[0], t.a0);
        drive_req(1, t.v[1], t.wr[1], t.a1);
        bus.dn_req_grant  = t.dgnt;
        bus.dn_resp.valid = t.rv;
        bus.dn_resp.data  = t.rd;
        bus.up_resp_grant = t.rg;
        @(negedge clk);
        chk($sformatf("row%0d dn_valid", row), 64'(bus.dn_req.valid), 64'(t.edv));
        if (t.edv) begin
            ea = (t.esel == 1) ? t.a1 : t.a0;
            chk($sformatf("row%0d dn_addr", row), 64'(bus.dn_req.addr), 64'(ea));
            chk($sformatf("row%0d dn_wr", row), 64'(bus.dn_req.isWrite), 64'(t.wr[t.esel]));
            chk($sformatf("row%0d dn_data", row), bus.dn_req.data, req_data(t.esel, ea));
        end
        chk($sformatf("row%0d up_grant", row), 64'(bus.up_req_grant), 64'(t.eug));
        for (int i = 0; i < NR; i++) exp_grants[i] += int'(t.eug[i]);
        chk($sformatf("row%0d up_resp_valid", row), 64'(resp_valids()), 64'(t.erv));
        if (t.erv != '0) chk($sformatf("row%0d up_resp_data", row), bus.dn_resp.data, t.rd);
        chk($sformatf("row%0d dn_resp_grant", row), 64'(bus.dn_resp_grant), 64'(t.edrg));
        chk($sformatf("row%0d busy", row), 64'(bus.busy), 64'(t.ebusy));
        next_cycle();
    endtask

    // Single read from requester id with an immediate decoder grant.
    task automatic issue_read(input int id, input logic [31:0] addr, input logic [63:0] rdata);
        sb_t e;
        idle_inputs();
        drive_req(id, 1'b1, 1'b0, addr);
        bus.dn_req_grant = 1'b1;
        @(negedge clk);
        chk($sformatf("rd%0d grant", id), 64'(bus.up_req_grant), 64'(1 << id));
        chk($sformatf("rd%0d dn_addr", id), 64'(bus.dn_req.addr), 64'(addr));
        exp_grants[id]++;
        e.id = id;
        e.data = rdata;
        sb_q.push_back(e);
        next_cycle();
        idle_inputs();
    endtask

    task automatic respond(input string name);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, no response expected", name);
            return;
        end
        e = sb_q.pop_front();
        idle_inputs();
        bus.dn_resp.valid = 1'b1;
        bus.dn_resp.data  = e.data;
        bus.up_resp_grant = '1;
        @(negedge clk);
        chk({name, " valid"}, 64'(bus.up_resp[e.id].valid), 64'(1'b1));
        chk({name, " data"}, bus.up_resp[e.id].data, e.data);
        for (int i = 0; i < NR; i++)
            if (i != e.id) chk({name, " other_valid"}, 64'(bus.up_resp[i].valid), 64'(1'b0));
        chk({name, " dn_resp_grant"}, 64'(bus.dn_resp_grant), 64'(1'b1));
        next_cycle();
        idle_inputs();
    endtask

`ifdef SOFTREG_ARB_STATS_EN
    task automatic chk_stats(input string name, input int exp_max, input logic exp_err);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s stat_grants%0d", name, i), 64'(stat_grants[i]), 64'(exp_grants[i]));
        chk({name, " stat_max"}, 64'(stat_max), 64'(exp_max));
        chk({name, " err_unsolicited"}, 64'(err_unsol), 64'(exp_err));
    endtask
`endif

    initial begin
        for (int i = 0; i < NR; i++) exp_grants[i] = 0;

        // Test 1: alternating writes; then idle.
        tv[0]  = mkv(2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 2'b00, 64'h0, 1, 0, 2'b01, 2'b00, 0, 0);
        tv[1]  = mkv(2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 2'b00, 64'h0, 1, 1, 2'b10, 2'b00, 0, 0);
        tv[2]  = mkv(2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 2'b00, 64'h0, 1, 0, 2'b01, 2'b00, 0, 0);
        tv[3]  = mkv(2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 2'b00, 64'h0, 1, 1, 2'b10, 2'b00, 0, 0);
        tv[4]  = mkv(2'b00, 2'b00, 32'h10, 32'h20, 1, 0, 2'b00, 64'h0, 0, 0, 2'b00, 2'b00, 0, 0);
        // Test 2: read on req0 stalled 3 cycles, req1 write waits.
        tv[5]  = mkv(2'b01, 2'b10, 32'h40, 32'h20, 0, 0, 2'b00, 64'h0, 1, 0, 2'b00, 2'b00, 0, 0);
        tv[6]  = mkv(2'b11, 2'b10, 32'h40, 32'h20, 0, 0, 2'b00, 64'h0, 1, 0, 2'b00, 2'b00, 0, 1);
        tv[7]  = mkv(2'b11, 2'b10, 32'h40, 32'h20, 0, 0, 2'b00, 64'h0, 1, 0, 2'b00, 2'b00, 0, 1);
        tv[8]  = mkv(2'b11, 2'b10, 32'h40, 32'h20, 1, 0, 2'b00, 64'h0, 1, 0, 2'b01, 2'b00, 0, 1);
        tv[9]  = mkv(2'b10, 2'b10, 32'h40, 32'h20, 1, 0, 2'b00, 64'h0, 1, 1, 2'b10, 2'b00, 0, 1);
        tv[10] = mkv(2'b00, 2'b00, 32'h0,  32'h0,  1, 1, 2'b01, 64'h1234_5678_9ABC_DEF0, 0, 0, 2'b00, 2'b01, 1, 1);
        tv[11] = mkv(2'b00, 2'b00, 32'h0,  32'h0,  0, 0, 2'b00, 64'h0, 0, 0, 2'b00, 2'b00, 0, 0);
        // Lock on req1, then it drops valid: release with no grant.
        tv[12] = mkv(2'b10, 2'b10, 32'h0,  32'h20, 0, 0, 2'b00, 64'h0, 1, 1, 2'b00, 2'b00, 0, 0);
        tv[13] = mkv(2'b00, 2'b10, 32'h0,  32'h20, 1, 0, 2'b00, 64'h0, 0, 0, 2'b00, 2'b00, 0, 1);
        tv[14] = mkv(2'b00, 2'b00, 32'h0,  32'h0,  1, 0, 2'b00, 64'h0, 0, 0, 2'b00, 2'b00, 0, 0);

        // Reset with live inputs: every output must stay low.
        idle_inputs();
        drive_req(0, 1'b1, 1'b1, 32'h10);
        bus.dn_req_grant  = 1'b1;
        bus.dn_resp.valid = 1'b1;
        bus.up_resp_grant = '1;
        #3;
        chk("reset dn_valid", 64'(bus.dn_req.valid), 64'(1'b0));
        chk("reset up_grant", 64'(bus.up_req_grant), 64'(0));
        chk("reset up_resp_valid", 64'(resp_valids()), 64'(0));
        chk("reset dn_resp_grant", 64'(bus.dn_resp_grant), 64'(1'b0));
        chk("reset busy", 64'(bus.busy), 64'(1'b0));
`ifdef SOFTREG_ARB_STATS_EN
        chk_stats("reset", 0, 1'b0);
`endif
        idle_inputs();
        #9 rst_n = 1'b1;
        next_cycle();

        for (int r = 0; r < 15; r++) apply_vec(tv[r], r);

        // Test 3: two reads, responses routed in order.
        issue_read(1, 32'h100, 64'hAAAA_0001);
        issue_read(0, 32'h200, 64'hBBBB_0002);
        respond("t3 resp1");
        respond("t3 resp0");
        @(negedge clk);
        chk("t3 busy_after", 64'(bus.busy), 64'(1'b0));
        next_cycle();

        // Test 4: FIFO full blocks reads but not writes.
        issue_read(0, 32'h300, 64'h3333_0000);
        issue_read(1, 32'h310, 64'h3333_0001);
        drive_req(0, 1'b1, 1'b0, 32'h320);
        drive_req(1, 1'b1, 1'b1, 32'h330);
        bus.dn_req_grant = 1'b1;
        @(negedge clk);
        chk("t4 write_addr", 64'(bus.dn_req.addr), 64'(32'h330));
        chk("t4 write_grant", 64'(bus.up_req_grant), 64'(2'b10));
        exp_grants[1]++;
        next_cycle();
        drive_req(1, 1'b0, 1'b0, 32'h0);
        bus.dn_resp.valid = 1'b1;
        bus.dn_resp.data  = sb_q[0].data;
        bus.up_resp_grant = 2'b01;
        @(negedge clk);
        chk("t4 blocked_valid", 64'(bus.dn_req.valid), 64'(1'b0));
        chk("t4 blocked_grant", 64'(bus.up_req_grant), 64'(0));
        chk("t4 pop_valid", 64'(resp_valids()), 64'(2'b01));
        chk("t4 pop_grant", 64'(bus.dn_resp_grant), 64'(1'b1));
        void'(sb_q.pop_front());
        next_cycle();
        bus.dn_resp.valid = 1'b0;
        bus.up_resp_grant = '0;
        @(negedge clk);
        chk("t4 third_addr", 64'(bus.dn_req.addr), 64'(32'h320));
        chk("t4 third_grant", 64'(bus.up_req_grant), 64'(2'b01));
        exp_grants[0]++;
        sb_q.push_back('{id: 0, data: 64'h3333_0002});
        next_cycle();
        idle_inputs();
        respond("t4 resp1");
        respond("t4 resp0");

        // Test 5: requester 0 stalls its response for 5 cycles.
        issue_read(0, 32'h500, 64'hC0FF_EE00_0000_0005);
        for (int c = 0; c < 5; c++) begin
            bus.dn_resp.valid = 1'b1;
            bus.dn_resp.data  = sb_q[0].data;
            bus.up_resp_grant = '0;
            @(negedge clk);
            chk($sformatf("t5 hold%0d valid", c), 64'(bus.up_resp[0].valid), 64'(1'b1));
            chk($sformatf("t5 hold%0d data", c), bus.up_resp[0].data, 64'hC0FF_EE00_0000_0005);
            chk($sformatf("t5 hold%0d dn_resp_grant", c), 64'(bus.dn_resp_grant), 64'(1'b0));
            chk($sformatf("t5 hold%0d busy", c), 64'(bus.busy), 64'(1'b1));
            next_cycle();
        end
        respond("t5 resp0");

        // Test 6: async reset while LOCKED with two reads outstanding.
        issue_read(1, 32'h600, 64'h6666_0001);
        issue_read(0, 32'h610, 64'h6666_0000);
        drive_req(1, 1'b1, 1'b1, 32'h620);
        bus.dn_req_grant = 1'b0;
        @(negedge clk);
        chk("t6 lock_addr", 64'(bus.dn_req.addr), 64'(32'h620));
        chk("t6 lock_grant", 64'(bus.up_req_grant), 64'(0));
        next_cycle();
        @(negedge clk);
        chk("t6 locked_busy", 64'(bus.busy), 64'(1'b1));
`ifdef SOFTREG_ARB_STATS_EN
        chk_stats("t6 pre_reset", 2, 1'b0);
`endif
        #1;
        rst_n = 1'b0;
        bus.dn_req_grant  = 1'b1;
        bus.dn_resp.valid = 1'b1;
        bus.up_resp_grant = '1;
        #1;
        chk("t6 rst dn_valid", 64'(bus.dn_req.valid), 64'(1'b0));
        chk("t6 rst up_grant", 64'(bus.up_req_grant), 64'(0));
        chk("t6 rst up_resp_valid", 64'(resp_valids()), 64'(0));
        chk("t6 rst dn_resp_grant", 64'(bus.dn_resp_grant), 64'(1'b0));
        chk("t6 rst busy", 64'(bus.busy), 64'(1'b0));
        sb_q.delete();
        for (int i = 0; i < NR; i++) exp_grants[i] = 0;
`ifdef SOFTREG_ARB_STATS_EN
        chk_stats("t6 in_reset", 0, 1'b0);
`endif
        idle_inputs();
        #1 rst_n = 1'b1;
        next_cycle();
        bus.dn_resp.valid = 1'b1;
        bus.dn_resp.data  = 64'hDEAD_BEEF;
        bus.up_resp_grant = '1;
        @(negedge clk);
        chk("t6 unsol dn_resp_grant", 64'(bus.dn_resp_grant), 64'(1'b1));
        chk("t6 unsol up_resp_valid", 64'(resp_valids()), 64'(0));
        chk("t6 unsol busy", 64'(bus.busy), 64'(1'b0));
        next_cycle();
        idle_inputs();
        drive_req(0, 1'b1, 1'b1, 32'h700);
        drive_req(1, 1'b1, 1'b1, 32'h710);
        bus.dn_req_grant = 1'b1;
        @(negedge clk);
        chk("t6 rr_after_reset", 64'(bus.up_req_grant), 64'(2'b01));
        exp_grants[0]++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
`ifdef SOFTREG_ARB_STATS_EN
        chk_stats("t6 post", 0, 1'b1);
`endif
        chk("end busy", 64'(bus.busy), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/softreg_arbiter.md
Name: softreg_arbiter

Overview:
- Shares one downstream SoftReg request/response channel among NUM_REQ upstream SoftReg masters, for example several AXI-Lite-to-SoftReg bridges or debug injectors.
- Arbitration is round-robin with a lock, so a presented request is held stable until the downstream grants it.
- Requester IDs of granted reads go into an in-order tag FIFO, so each read response returns to its issuer.
- Sits between the shell-side bridges and the app SoftReg decoder.

Parameters:
- NUM_REQ, 2: number of upstream requesters, 2..8.
- LOG_OUTSTANDING, 3: log2 depth of the read-ID FIFO, i.e. the maximum number of outstanding reads.
- ID_W, $clog2(NUM_REQ) (min 1): requester ID width (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- up_req  in  SoftRegReq[NUM_REQ]  upstream requests (valid, isWrite, addr[31:0], data[63:0])
- up_req_grant  out  [NUM_REQ]  one-hot accept, per requester
- up_resp  out  SoftRegResp[NUM_REQ]  per-requester read responses
- up_resp_grant  in  [NUM_REQ]  requester accepts its response
- dn_req  out  SoftRegReq  request to the SoftReg decoder
- dn_req_grant  in  1  decoder accepts dn_req
- dn_resp  in  SoftRegResp  in-order read response from the decoder
- dn_resp_grant  out  1  arbiter accepts dn_resp
- busy  out  1  high while any read is outstanding or the arbiter is LOCKED

Behaviour:
Reset (async, rst_n=0):
- State goes to IDLE; rr_ptr=0; ID FIFO is empty.
- All outputs deassert: dn_req.valid=0, up_req_grant=0, up_resp[*].valid=0, dn_resp_grant=0, busy=0.

Eligibility:
- Requester i is eligible if up_req[i].valid is high and either its isWrite=1 or the ID FIFO is not full.
- A pop in the same cycle does not free a slot for eligibility (conservative).

IDLE state:
- Pick the first eligible index, searching rr_ptr, rr_ptr+1, … mod NUM_REQ. If there is none, dn_req.valid=0.
- Drive dn_req combinationally from the chosen requester (sel).
- If dn_req_grant=1 in the same cycle:
  - up_req_grant[sel]=1.
  - rr_ptr <= (sel+1) mod NUM_REQ.
  - If it is a read, push sel to the ID FIFO.
  - Zero-cycle acceptance.
- If dn_req_grant=0: go to LOCKED and register lock_id=sel.

LOCKED state:
- dn_req is driven from up_req[lock_id] only. Eligibility is not re-evaluated, because the FIFO cannot fill while a read is pending.
- On dn_req_grant: up_req_grant[lock_id]=1, push if read, rr_ptr <= lock_id+1, return to IDLE.
- Requesters must hold valid until granted. If up_req[lock_id].valid drops, it is a protocol error: return to IDLE with no grant.

Response routing:
- up_resp[head].valid = dn_resp.valid && !fifo_empty.
- up_resp[head].data = dn_resp.data. All other up_resp[*].valid=0.
- dn_resp_grant = up_resp_grant[head] && up_resp[head].valid. The FIFO pops on the same cycle.
- dn_resp.valid while the FIFO is empty is an unsolicited response: dn_resp_grant=1, the response is dropped, and sticky err_unsolicited is set (internal; exposed under the macro below).

Simultaneous events:
- Push and pop in one cycle: the occupancy count is unchanged.
- Pointers wrap modulo 2^LOG_OUTSTANDING.
- The occupancy counter is LOG_OUTSTANDING+1 bits wide.

Writes:
- Writes never touch the FIFO and get no response.

busy = (state==LOCKED) || !fifo_empty.

Optional Feature:
SOFTREG_ARB_STATS_EN:
- When defined, adds output stat_grants[NUM_REQ][31:0], a saturating per-requester grant counter.
- Adds output stat_max_outstanding[LOG_OUTSTANDING:0], the high-water mark of FIFO occupancy.
- Adds output err_unsolicited, a sticky bit.
- All three clear on reset.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- AOSF1Types gains:
  - SR_ARB_NUM_REQ_DEFAULT and SR_ARB_LOG_OUTSTANDING_DEFAULT constants.
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} SrArbState.
- SoftRegReq and SoftRegResp are reused from AMITypes.
- One sub-module: sr_arb_id_fifo, a ID_W-wide, 2^LOG_OUTSTANDING-deep FIFO with async-low reset, full/empty flags and a count output. HullFIFO is not used because its reset and full-lookahead semantics do not fit.

Test Plan:
1. Two requesters, NUM_REQ=2, both post writes every cycle, dn_req_grant=1 → grants alternate 0,1,0,1; four writes addr 0x10/0x20 complete in 4 cycles; FIFO stays empty.
2. Req0 read addr 0x40 with dn_req_grant held 0 for 3 cycles, and req1 asserts a write meanwhile → dn_req stays addr 0x40 (LOCKED); req0 is granted first on cycle 4, then req1.
3. Req1 read, then req0 read; decoder returns 0xAAAA_0001 then 0xBBBB_0002 → up_resp[1] gets 0xAAAA_0001, then up_resp[0] gets 0xBBBB_0002.
4. LOG_OUTSTANDING=1, two reads granted with no responses → third read is not offered; a concurrent write from the other requester is still granted; after one response pops, the third read is granted the next cycle.
5. up_resp_grant[0] held 0 for 5 cycles while a response is pending → dn_resp_grant=0 and the data is held; pop occurs on the grant cycle.
6. rst_n asserted mid-LOCKED with 2 reads outstanding → all outputs 0 immediately (async); after release, a dn_resp.valid is dropped, and err_unsolicited=1 with the stats macro defined.
